// File: rtl/test_logic_if.sv
// ============================================================================
// Module      : test_logic_if
// Description : Operand/opcode/result bundle for the registered logic unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface test_logic_if;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] res;

    modport master (
        output a,
        output b,
        output op,
        input  res
    );

    modport slave (
        input  a,
        input  b,
        input  op,
        output res
    );
endinterface

`default_nettype wire

// File: rtl/test_logic.sv
// ============================================================================
// Module      : test_logic
// Description : Registered 16-bit bitwise logic unit, 1-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module test_logic (
    input  wire logic   clk,
    input  wire logic   rst,
    test_logic_if.slave bus
);

    localparam logic [2:0] c_OP_AND   = 3'b000;
    localparam logic [2:0] c_OP_OR    = 3'b001;
    localparam logic [2:0] c_OP_XOR   = 3'b010;
    localparam logic [2:0] c_OP_NAND  = 3'b011;
    localparam logic [2:0] c_OP_NOR   = 3'b100;
    localparam logic [2:0] c_OP_XNOR  = 3'b101;
    localparam logic [2:0] c_OP_ANDN  = 3'b110;
    localparam logic [2:0] c_OP_SPLIT = 3'b111;

    logic [15:0] w_res;
    logic [15:0] r_res;

    always_comb begin
        w_res = 16'h0000;
        case (bus.op)
            c_OP_AND:   w_res = bus.a & bus.b;
            c_OP_OR:    w_res = bus.a | bus.b;
            c_OP_XOR:   w_res = bus.a ^ bus.b;
            c_OP_NAND:  w_res = ~(bus.a & bus.b);
            c_OP_NOR:   w_res = ~(bus.a | bus.b);
            c_OP_XNOR:  w_res = ~(bus.a ^ bus.b);
            c_OP_ANDN:  w_res = bus.a & ~bus.b;
            // High byte XOR, low byte AND
            c_OP_SPLIT: w_res = {bus.a[15:8] ^ bus.b[15:8], bus.a[7:0] & bus.b[7:0]};
            default:    w_res = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= 16'h0000;
        end else begin
            r_res <= w_res;
        end
    end

    assign bus.res = r_res;

endmodule

`default_nettype wire

// File: tb/tb_test_logic.sv
// ============================================================================
// Module      : tb_test_logic
// Description : Self-checking bench for test_logic: directed plan + random.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_test_logic;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    test_logic_if u_if ();

    test_logic u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-bit truth tables indexed by {a_bit, b_bit}; opcode 7 is positional.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
        logic [3:0] tt [0:6];
        logic [15:0] r;
        tt[0] = 4'b1000; // AND
        tt[1] = 4'b1110; // OR
        tt[2] = 4'b0110; // XOR
        tt[3] = 4'b0111; // NAND
        tt[4] = 4'b0001; // NOR
        tt[5] = 4'b1001; // XNOR
        tt[6] = 4'b0100; // A AND NOT B
        r = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (op == 3'd7) begin
                r[i] = (i >= 8) ? (a[i] != b[i]) : (a[i] && b[i]);
            end else begin
                r[i] = tt[op][{a[i], b[i]}];
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: res=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input string tag, input logic r, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] op, input logic [15:0] exp);
        @(negedge clk);
        rst    = r;
        u_if.a  = a;
        u_if.b  = b;
        u_if.op = op;
        @(posedge clk);
        #1;
        chk(tag, u_if.res, exp);
    endtask

    logic [15:0] seq_exp [0:7];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        u_if.a   = 16'h0;
        u_if.b   = 16'h0;
        u_if.op  = 3'd0;

        apply("reset0", 1'b1, 16'hFFFF, 16'hFFFF, 3'd1, 16'h0000);
        apply("reset1", 1'b1, 16'hFFFF, 16'hFFFF, 3'd1, 16'h0000);
        apply("first_after_reset", 1'b0, 16'hFFFF, 16'hFFFF, 3'd1, 16'hFFFF);

        apply("v1_and",  1'b0, 16'h000A, 16'h0005, 3'd0, 16'h0000);
        apply("v1_or",   1'b0, 16'h000A, 16'h0005, 3'd1, 16'h000F);
        apply("v1_xor",  1'b0, 16'h000A, 16'h0005, 3'd2, 16'h000F);
        apply("v1_nand", 1'b0, 16'h000A, 16'h0005, 3'd3, 16'hFFFF);
        apply("v1_xnor", 1'b0, 16'h000A, 16'h0005, 3'd5, 16'hFFF0);

        apply("v2_and", 1'b0, 16'hA94B, 16'hA2B4, 3'd0, 16'hA000);
        apply("v2_or",  1'b0, 16'hA94B, 16'hA2B4, 3'd1, 16'hABFF);
        apply("v2_xor", 1'b0, 16'hA94B, 16'hA2B4, 3'd2, 16'h0BFF);
        apply("v2_nor", 1'b0, 16'hA94B, 16'hA2B4, 3'd4, 16'h5400);

        apply("v3_and",   1'b0, 16'hADBB, 16'hAA55, 3'd0, 16'hA811);
        apply("v3_or",    1'b0, 16'hADBB, 16'hAA55, 3'd1, 16'hAFFF);
        apply("v3_xor",   1'b0, 16'hADBB, 16'hAA55, 3'd2, 16'h07EE);
        apply("v3_andn",  1'b0, 16'hADBB, 16'hAA55, 3'd6, 16'h05AA);
        apply("v3_split", 1'b0, 16'hADBB, 16'hAA55, 3'd7, 16'h0711);

        seq_exp[0] = 16'hA811; seq_exp[1] = 16'hAFFF;
        seq_exp[2] = 16'h07EE; seq_exp[3] = 16'h57EE;
        seq_exp[4] = 16'h5000; seq_exp[5] = 16'hF811;
        seq_exp[6] = 16'h05AA; seq_exp[7] = 16'h0711;
        for (int i = 0; i < 8; i++) begin
            apply($sformatf("seq_op%0d", i), 1'b0, 16'hADBB, 16'hAA55, 3'(i), seq_exp[i]);
        end

        apply("mid_and",    1'b0, 16'hA94B, 16'hA2B4, 3'd0, 16'hA000);
        apply("mid_or",     1'b0, 16'hA94B, 16'hA2B4, 3'd1, 16'hABFF);
        apply("mid_rst",    1'b1, 16'hA94B, 16'hA2B4, 3'd2, 16'h0000);
        apply("mid_resume", 1'b0, 16'hA94B, 16'hA2B4, 3'd2, 16'h0BFF);
        apply("mid_nor",    1'b0, 16'hA94B, 16'hA2B4, 3'd4, 16'h5400);

        for (int i = 0; i < 500; i++) begin
            logic [15:0] ra, rb;
            logic [2:0]  rop;
            logic        rr;
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rop = 3'($urandom_range(7, 0));
            rr  = ($urandom_range(15, 0) == 0);
            apply($sformatf("rand%0d_op%0d", i, rop), rr, ra, rb, rop,
                  rr ? 16'h0000 : model(ra, rb, rop));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
